// File: rtl/conv_channel_accumulator.sv
// Sums per-lane conv results over PASSES passes, adds per-filter bias, saturates, ReLUs, streams pixels.
// Latency: final-pass beat accepted in cycle t -> out_valid in t+2. A stalled output freezes the pipe and drops in_ready.
// Optional saturation event counter: define CONV_ACC_SAT_COUNT_EN to add the sat_count port.
module conv_channel_accumulator #(
  parameter int DATA_WIDTH        = 16,
  parameter int FRAC_BITS         = 8,
  parameter int NUMBER_OF_UNITS   = 3,
  parameter int IFM_DEPTH         = 6,
  parameter int OFM_PIXELS        = 784,
  parameter int NUMBER_OF_FILTERS = 6,
  localparam int FSEL_W = (NUMBER_OF_FILTERS > 1) ? $clog2(NUMBER_OF_FILTERS) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [FSEL_W-1:0]                     filter_sel,
  input  logic                                  bias_wr_en,
  input  logic [FSEL_W-1:0]                     bias_wr_addr,
  input  logic [DATA_WIDTH-1:0]                 bias_wr_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] unit_data_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic                                  out_last,
  output logic                                  busy,
`ifdef CONV_ACC_SAT_COUNT_EN
  output logic [15:0]                           sat_count,
`endif
  output logic                                  done
);

  localparam int PASSES     = (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS;
  localparam int LAST_LANES = IFM_DEPTH - (PASSES - 1) * NUMBER_OF_UNITS;
  localparam int PASS_W     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int PIX_W      = $clog2(OFM_PIXELS);
  localparam int SUM_W      = DATA_WIDTH + $clog2(NUMBER_OF_UNITS) + 1;
  localparam int ACC_W      = SUM_W + 1;

  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(OFM_PIXELS - 1);
  localparam logic signed [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] A_MAX = ACC_W'(D_MAX);
  localparam logic signed [ACC_W-1:0] A_MIN = ACC_W'(D_MIN);

  if (OFM_PIXELS < 4 || FRAC_BITS >= DATA_WIDTH) begin : g_bad_params
    $error("conv_channel_accumulator: OFM_PIXELS must be >= 4 and FRAC_BITS < DATA_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic                    vld;
    logic                    first;
    logic                    is_final;
    logic                    last;
    logic [PIX_W-1:0]        pix;
    logic signed [SUM_W-1:0] sum;
  } s1_t;

  state_t                         state, state_nxt;
  logic [PASS_W-1:0]              pass_cnt;
  logic [PIX_W-1:0]               pix_cnt;
  logic [FSEL_W-1:0]              filt;
  logic signed [DATA_WIDTH-1:0]   bias_bank [NUMBER_OF_FILTERS];
  s1_t                            s1;
  logic                           stall, accept, beat_final, beat_last, s2_go;
  logic signed [SUM_W-1:0]        lane_sum;
  logic signed [DATA_WIDTH-1:0]   psum_rd, addend, acc_sat;
  logic signed [ACC_W-1:0]        acc;
  logic                           ovf_hi, ovf_lo;

  assign stall      = out_valid && !out_ready;
  assign in_ready   = (state == RUN) && !stall;
  assign accept     = in_valid && in_ready;
  assign beat_final = (pass_cnt == PASS_LAST);
  assign beat_last  = beat_final && (pix_cnt == PIX_LAST);
  assign s2_go      = s1.vld && !stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (accept && beat_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (out_valid && out_ready && out_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_cnt <= '0;
      pix_cnt  <= '0;
      filt     <= '0;
    end else if (state == IDLE && start) begin
      pass_cnt <= '0;
      pix_cnt  <= '0;
      filt     <= filter_sel;
    end else if (accept) begin
      if (pix_cnt == PIX_LAST) begin
        pix_cnt  <= '0;
        pass_cnt <= pass_cnt + 1'b1;
      end else begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bias_wr_en && int'(bias_wr_addr) < NUMBER_OF_FILTERS)
      bias_bank[bias_wr_addr] <= bias_wr_data;
  end

  // Lanes beyond the channel count are ignored on the final pass.
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < NUMBER_OF_UNITS; k++) begin
      if (!(beat_final && k >= LAST_LANES))
        lane_sum = lane_sum + SUM_W'($signed(unit_data_in[k*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
    end else if (!stall) begin
      s1.vld      <= accept;
      s1.first    <= (pass_cnt == '0);
      s1.is_final <= beat_final;
      s1.last     <= beat_last;
      s1.pix      <= pix_cnt;
      s1.sum      <= lane_sum;
    end
  end

  if (PASSES > 1) begin : g_psum
    logic signed [DATA_WIDTH-1:0] psum_mem [OFM_PIXELS];
    always_ff @(posedge clk) begin
      if (accept)
        psum_rd <= psum_mem[pix_cnt];
      if (s2_go && !s1.is_final)
        psum_mem[s1.pix] <= acc_sat;
    end
  end else begin : g_no_psum
    assign psum_rd = '0;
  end

  always_comb begin
    addend  = s1.first ? bias_bank[filt] : psum_rd;
    acc     = ACC_W'($signed(s1.sum)) + ACC_W'(addend);
    ovf_hi  = (acc > A_MAX);
    ovf_lo  = (acc < A_MIN);
    acc_sat = ovf_hi ? D_MAX : (ovf_lo ? D_MIN : acc[DATA_WIDTH-1:0]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (s2_go && s1.is_final) begin
      out_valid <= 1'b1;
      out_data  <= acc_sat[DATA_WIDTH-1] ? '0 : acc_sat;
      out_last  <= s1.last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

`ifdef CONV_ACC_SAT_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sat_count <= '0;
    else if (state == IDLE && start)
      sat_count <= '0;
    else if (s2_go && (ovf_hi || ovf_lo) && sat_count != 16'hFFFF)
      sat_count <= sat_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_conv_channel_accumulator.sv
// Bench: single-pass DUT (16-bit, 3 channels) and two-pass DUT (8-bit, 5 channels), 4-pixel maps.
module tb_conv_channel_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, bias_wr_en, in_valid, out_ready, sel;
  logic [2:0]  filter_sel, bias_wr_addr;
  logic [15:0] bias_wr_data;
  logic [47:0] data_a;
  logic [23:0] data_b;

  logic        in_ready_a, out_valid_a, out_last_a, busy_a, done_a;
  logic        in_ready_b, out_valid_b, out_last_b, busy_b, done_b;
  logic [15:0] out_data_a;
  logic [7:0]  out_data_b;
`ifdef CONV_ACC_SAT_COUNT_EN
  logic [15:0] sat_count_a, sat_count_b;
`endif

  conv_channel_accumulator #(.DATA_WIDTH(16), .FRAC_BITS(8), .NUMBER_OF_UNITS(3),
    .IFM_DEPTH(3), .OFM_PIXELS(4), .NUMBER_OF_FILTERS(6)) dut_a (
    .clk(clk), .reset(reset), .start(start && !sel), .filter_sel(filter_sel),
    .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
    .in_valid(in_valid && !sel), .in_ready(in_ready_a), .unit_data_in(data_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_last(out_last_a), .busy(busy_a),
`ifdef CONV_ACC_SAT_COUNT_EN
    .sat_count(sat_count_a),
`endif
    .done(done_a));

  conv_channel_accumulator #(.DATA_WIDTH(8), .FRAC_BITS(4), .NUMBER_OF_UNITS(3),
    .IFM_DEPTH(5), .OFM_PIXELS(4), .NUMBER_OF_FILTERS(6)) dut_b (
    .clk(clk), .reset(reset), .start(start && sel), .filter_sel(filter_sel),
    .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data[7:0]),
    .in_valid(in_valid && sel), .in_ready(in_ready_b), .unit_data_in(data_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_last(out_last_b), .busy(busy_b),
`ifdef CONV_ACC_SAT_COUNT_EN
    .sat_count(sat_count_b),
`endif
    .done(done_b));

  wire        in_ready_m  = sel ? in_ready_b  : in_ready_a;
  wire        out_valid_m = sel ? out_valid_b : out_valid_a;
  wire        out_last_m  = sel ? out_last_b  : out_last_a;
  wire        busy_m      = sel ? busy_b      : busy_a;
  wire        done_m      = sel ? done_b      : done_a;
  wire [15:0] out_data_m  = sel ? {{8{out_data_b[7]}}, out_data_b} : out_data_a;

  // Output monitor: every handshake is recorded with the cycle it was seen in.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int got_q[$];
  int last_q[$];
  int gcyc_q[$];
  int vcnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  always @(negedge clk) begin
    if (out_valid_m) vcnt++;
    if (out_valid_m && out_ready) begin
      got_q.push_back(int'($signed(out_data_m)));
      last_q.push_back(int'(out_last_m));
      gcyc_q.push_back(cyc);
    end
    if (done_m) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  typedef struct { int l0; int l1; int l2; int exp; } vec_t;
  vec_t tv[4];

  int checks = 0;
  int errors = 0;
  int bl[8][3];
  int acc_c[8];
  int exp_o[4];
  int sat_m;
  bit drv_done;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int i);
    bit ok;
    ok = 1'b0;
    data_a   = {16'(bl[i][2]), 16'(bl[i][1]), 16'(bl[i][0])};
    data_b   = {8'(bl[i][2]), 8'(bl[i][1]), 8'(bl[i][0])};
    in_valid = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (in_ready_m) begin
        acc_c[i] = cyc;
        ok = 1'b1;
      end
    end
    if (!ok) chk($sformatf("in_accept_timeout_beat%0d", i), int'(ok), 1);
    else     step();
  endtask

  task automatic send_range(input int from, input int to);
    for (int i = from; i <= to; i++) send_beat(i);
    in_valid = 1'b0;
  endtask

  task automatic start_map(input int f);
    filter_sel = 3'(f);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wr_bias(input int a, input int d);
    bias_wr_en   = 1'b1;
    bias_wr_addr = 3'(a);
    bias_wr_data = 16'(d);
    step();
    bias_wr_en = 1'b0;
  endtask

  task automatic wait_out(input int base, input int n);
    for (int c = 0; c < 3000 && got_q.size() < base + n; c++) @(negedge clk);
    if (got_q.size() < base + n) chk("out_count_timeout", got_q.size(), base + n);
    repeat (3) step();
  endtask

  task automatic check_outs(input string nm, input int base);
    for (int i = 0; i < 4; i++) begin
      if (base + i < got_q.size()) begin
        chk($sformatf("%s_out%0d", nm, i), got_q[base+i], exp_o[i]);
        chk($sformatf("%s_last%0d", nm, i), last_q[base+i], (i == 3) ? 1 : 0);
      end
    end
  endtask

  task automatic load_t1();
    for (int i = 0; i < 4; i++) begin
      bl[i][0] = tv[i].l0; bl[i][1] = tv[i].l1; bl[i][2] = tv[i].l2;
      exp_o[i] = tv[i].exp;
    end
  endtask

  task automatic run_t1(input string nm, input bit check_lat);
    int base, dbase;
    base  = got_q.size();
    dbase = done_cnt;
    load_t1();
    start_map(2);
    send_range(0, 3);
    wait_out(base, 4);
    check_outs(nm, base);
    if (got_q.size() >= base + 4) begin
      if (check_lat)
        for (int i = 0; i < 4; i++)
          chk($sformatf("%s_latency%0d", nm, i), gcyc_q[base+i] - acc_c[i], 2);
      chk({nm, "_done_count"}, done_cnt - dbase, 1);
      chk({nm, "_done_after_last"}, done_cyc - gcyc_q[base+3], 1);
    end
    chk({nm, "_busy_after"}, int'(busy_m), 0);
  endtask

  // Two-pass, 8-bit reference: saturating running sum per pixel, lane 2 dropped on the last pass.
  function automatic void model_b(input int bias);
    int acc, s, v;
    sat_m = 0;
    for (int p = 0; p < 4; p++) begin
      acc = 0;
      for (int ps = 0; ps < 2; ps++) begin
        s = 0;
        for (int k = 0; k < ((ps == 1) ? 2 : 3); k++) s += bl[ps*4+p][k];
        v   = s + ((ps == 0) ? bias : acc);
        acc = (v > 127) ? 127 : ((v < -128) ? -128 : v);
        if (acc != v) sat_m++;
      end
      exp_o[p] = (acc < 0) ? 0 : acc;
    end
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1);
  end

  initial begin
    int base, v0, d, b, f;
    bit ok;
    tv[0] = '{1, 2, 3, 16};
    tv[1] = '{-20, 1, 1, 0};
    tv[2] = '{0, 0, 0, 10};
    tv[3] = '{5, 5, 5, 25};

    reset = 1'b0; start = 1'b0; filter_sel = '0; bias_wr_en = 1'b0; bias_wr_addr = '0;
    bias_wr_data = '0; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0; data_a = '0; data_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready_a",  int'(in_ready_a), 0);
    chk("rst_out_valid_a", int'(out_valid_a), 0);
    chk("rst_out_data_a",  int'(out_data_a), 0);
    chk("rst_out_last_a",  int'(out_last_a), 0);
    chk("rst_busy_a",      int'(busy_a), 0);
    chk("rst_done_a",      int'(done_a), 0);
    chk("rst_out_valid_b", int'(out_valid_b), 0);
    chk("rst_in_ready_b",  int'(in_ready_b), 0);
    step();
    reset = 1'b1;
    step();

    // Single pass with bias, latency and done timing.
    wr_bias(2, 10);
    run_t1("t1", 1'b1);

    // Backpressure: hold the first output for 5 cycles.
    base = got_q.size();
    load_t1();
    start_map(2);
    fork
      send_range(0, 3);
      begin
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
          step();
          if (out_valid_m) ok = 1'b1;
        end
        if (!ok) chk("bp_wait_valid", int'(ok), 1);
        else begin
          out_ready = 1'b0;
          d = int'(out_data_m);
          for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_in_ready%0d", c), int'(in_ready_m), 0);
            chk($sformatf("bp_hold%0d", c), int'(out_data_m), d);
          end
          step();
          out_ready = 1'b1;
        end
      end
    join
    wait_out(base, 4);
    check_outs("t4", base);

    // Reset mid-run after two accepted beats, then a clean rerun.
    load_t1();
    start_map(2);
    send_beat(0);
    send_beat(1);
    reset = 1'b0;
    #1;
    chk("t5_out_valid", int'(out_valid_m), 0);
    chk("t5_busy",      int'(busy_m), 0);
    chk("t5_in_ready",  int'(in_ready_m), 0);
    in_valid = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    wr_bias(2, 10);
    run_t1("t5", 1'b0);

    // start while busy must not relatch filter_sel.
    wr_bias(0, -50);
    base = got_q.size();
    load_t1();
    start_map(2);
    fork
      send_range(0, 3);
      begin
        step(); step();
        filter_sel = 3'd0;
        start = 1'b1;
        step();
        start = 1'b0;
      end
    join
    wait_out(base, 4);
    check_outs("t6", base);

    // Two passes, lane 2 masked on the last pass.
    sel = 1'b1;
    wr_bias(0, 0);
    for (int i = 0; i < 4; i++) begin
      bl[i]   = '{1, 1, 1};
      bl[i+4] = '{2, 2, 99};
      exp_o[i] = 7;
    end
    base = got_q.size();
    start_map(0);
    v0 = vcnt;
    send_range(0, 3);
    repeat (3) step();
    chk("t2_no_valid_pass0", vcnt - v0, 0);
    send_range(4, 7);
    wait_out(base, 4);
    check_outs("t2", base);

    // Saturation in both directions.
    for (int i = 0; i < 8; i++) bl[i] = '{0, 0, 0};
    bl[0] = '{100, 100, 100};
    bl[1] = '{-100, -100, -100};
    exp_o = '{127, 0, 0, 0};
    base = got_q.size();
    start_map(0);
    send_range(0, 7);
    wait_out(base, 4);
    check_outs("t3", base);
`ifdef CONV_ACC_SAT_COUNT_EN
    chk("t3_sat_count", int'(sat_count_b), 2);
`endif

    // Random two-pass maps with random bias and random output backpressure.
    for (int m = 0; m < 6; m++) begin
      b = int'($urandom_range(0, 255)) - 128;
      f = int'($urandom_range(0, 5));
      wr_bias(f, b);
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < 3; k++) bl[i][k] = int'($urandom_range(0, 255)) - 128;
      model_b(b);
      base = got_q.size();
      drv_done = 1'b0;
      start_map(f);
      fork
        begin
          send_range(0, 7);
          drv_done = 1'b1;
        end
        begin
          for (int c = 0; c < 2000 && !(drv_done && got_q.size() >= base + 4); c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            step();
          end
          out_ready = 1'b1;
        end
      join
      wait_out(base, 4);
      check_outs($sformatf("rand%0d", m), base);
`ifdef CONV_ACC_SAT_COUNT_EN
      chk($sformatf("rand%0d_sat_count", m), int'(sat_count_b), sat_m);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
